// File: rtl/uart_rx_pkg.sv
// Shared types and limits for the RX deglitch filter.
// Filter mode, legal parameter ranges and the majority threshold.
package uart_rx_pkg;

   typedef enum logic {
      FILT_UNANIMOUS = 1'b0,
      FILT_MAJORITY  = 1'b1
   } filt_mode_e;

   localparam int DEPTH_MIN = 3;
   localparam int DEPTH_MAX = 15;
   localparam int CH_MAX    = 8;

   function automatic int maj_thresh(input int depth);
      return (depth + 1) / 2;
   endfunction

endpackage

// File: rtl/rx_filter_chan.sv
// One RX channel: 2-flop synchroniser, sample window, filter,
// falling-edge and rejected-glitch pulse generation.
module rx_filter_chan
   import uart_rx_pkg::*;
#(
   parameter int         DEPTH = 3,
   parameter filt_mode_e MODE  = FILT_UNANIMOUS
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rxc_i,
   input  logic rxen_i,
   input  logic rxd_i,
   output logic rxd_o,
   output logic fall_o,
   output logic glitch_o
);

   logic [1:0]       sync_q;
   logic [DEPTH-1:0] win_q, win_d, win_sh;
   logic             out_q, out_d;
   logic             prev_q;
   logic             dist_q, dist_d;
   logic             fall_q, fall_d;
   logic             glitch_q, glitch_d;
   logic             all1, all0, filt;

   assign win_sh = {win_q[DEPTH-2:0], sync_q[1]};
   assign all1   = &win_sh;
   assign all0   = ~|win_sh;

   if (MODE == FILT_MAJORITY) begin : g_maj
      localparam int CW = $clog2(DEPTH + 1);
      logic [CW-1:0] ones;
      always_comb begin
         ones = '0;
         for (int i = 0; i < DEPTH; i++) begin
            ones = ones + CW'(win_sh[i]);
         end
      end
      assign filt = (ones >= CW'(maj_thresh(DEPTH)));
   end else begin : g_unan
      assign filt = all1 | (~all0 & out_q);
   end

   always_comb begin
      win_d    = win_q;
      out_d    = out_q;
      dist_d   = dist_q;
      fall_d   = 1'b0;
      glitch_d = 1'b0;
      if (!rxen_i) begin
         win_d  = '1;
         out_d  = 1'b1;
         dist_d = 1'b0;
      end else begin
         fall_d = prev_q & ~out_q;
         if (rxc_i) begin
            win_d = win_sh;
            out_d = filt;
            // A real transition ends the disturbance silently.
            if (filt != out_q) begin
               dist_d = 1'b0;
            end else if (all1 | all0) begin
               dist_d   = 1'b0;
               glitch_d = dist_q;
            end else begin
               dist_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= '1;
         win_q    <= '1;
         out_q    <= 1'b1;
         prev_q   <= 1'b1;
         dist_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], rxd_i};
         win_q    <= win_d;
         out_q    <= out_d;
         prev_q   <= out_q;
         dist_q   <= dist_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
      end
   end

   assign rxd_o    = out_q;
   assign fall_o   = fall_q;
   assign glitch_o = glitch_q;

endmodule

// File: rtl/rx_deglitch_filter.sv
// Multi-channel RX deglitch filter: parameter checks and
// one independent filter channel per RX input.
module rx_deglitch_filter
   import uart_rx_pkg::*;
#(
   parameter int         CH    = 1,
   parameter int         DEPTH = 3,
   parameter filt_mode_e MODE  = FILT_UNANIMOUS
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          RXC,
   input  logic          RXEN,
   input  logic [CH-1:0] RXD_IN,
   output logic [CH-1:0] RXD_OUT,
   output logic [CH-1:0] EDGE_FALL,
   output logic [CH-1:0] GLITCH
);

   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
       (DEPTH % 2) == 0) begin : g_bad_depth
      $error("rx_deglitch_filter: illegal DEPTH %0d", DEPTH);
   end

   if (CH < 1 || CH > CH_MAX) begin : g_bad_ch
      $error("rx_deglitch_filter: illegal CH %0d", CH);
   end

   for (genvar c = 0; c < CH; c++) begin : g_chan
      rx_filter_chan #(
         .DEPTH (DEPTH),
         .MODE  (MODE)
      ) u_chan (
         .clk_i    (CLK),
         .rst_ni   (RST_N),
         .rxc_i    (RXC),
         .rxen_i   (RXEN),
         .rxd_i    (RXD_IN[c]),
         .rxd_o    (RXD_OUT[c]),
         .fall_o   (EDGE_FALL[c]),
         .glitch_o (GLITCH[c])
      );
   end

endmodule

// File: tb/tb_rx_deglitch_filter.sv
// Directed bench for rx_deglitch_filter: four configurations
// sharing clock, reset, tick and enable.
module tb_rx_deglitch_filter;
   import uart_rx_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rxc = 1'b0;
   logic       rxen = 1'b1;
   logic       rxd1 = 1'b1;
   logic [3:0] rxd4 = 4'hF;

   logic       o3, f3, g3;
   logic       o5u, f5u, g5u;
   logic       o5m, f5m, g5m;
   logic [3:0] o4, f4, g4;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   rx_deglitch_filter #(.CH(1), .DEPTH(3), .MODE(FILT_UNANIMOUS)) u_d3 (
      .CLK(clk), .RST_N(rst_n), .RXC(rxc), .RXEN(rxen),
      .RXD_IN(rxd1), .RXD_OUT(o3), .EDGE_FALL(f3), .GLITCH(g3)
   );

   rx_deglitch_filter #(.CH(1), .DEPTH(5), .MODE(FILT_UNANIMOUS)) u_d5u (
      .CLK(clk), .RST_N(rst_n), .RXC(rxc), .RXEN(rxen),
      .RXD_IN(rxd1), .RXD_OUT(o5u), .EDGE_FALL(f5u), .GLITCH(g5u)
   );

   rx_deglitch_filter #(.CH(1), .DEPTH(5), .MODE(FILT_MAJORITY)) u_d5m (
      .CLK(clk), .RST_N(rst_n), .RXC(rxc), .RXEN(rxen),
      .RXD_IN(rxd1), .RXD_OUT(o5m), .EDGE_FALL(f5m), .GLITCH(g5m)
   );

   rx_deglitch_filter #(.CH(4), .DEPTH(3), .MODE(FILT_UNANIMOUS)) u_c4 (
      .CLK(clk), .RST_N(rst_n), .RXC(rxc), .RXEN(rxen),
      .RXD_IN(rxd4), .RXD_OUT(o4), .EDGE_FALL(f4), .GLITCH(g4)
   );

   task automatic tick();
      repeat (3) @(negedge clk);
      rxc = 1'b1;
      @(posedge clk);
      #1 rxc = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rxc   = 1'b0;
      rxen  = 1'b1;
      rxd1  = 1'b1;
      rxd4  = 4'hF;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rxd1  = 1'b0;
      rxd4  = 4'h0;
      rst_n = 1'b0;
      #1;
      nvec++;
      if (o3 !== 1'b1) begin
         nerr++; $display("FAIL rst_out got %b exp 1", o3);
      end
      nvec++;
      if (f3 !== 1'b0 || g3 !== 1'b0) begin
         nerr++; $display("FAIL rst_pulses got %b%b exp 00", f3, g3);
      end
      nvec++;
      if (o4 !== 4'hF || f4 !== 4'h0 || g4 !== 4'h0) begin
         nerr++; $display("FAIL rst_c4 got %h %h %h exp f 0 0", o4, f4, g4);
      end
      repeat (3) @(negedge clk);
      nvec++;
      if (o5m !== 1'b1 || o5u !== 1'b1) begin
         nerr++; $display("FAIL rst_held got %b%b exp 11", o5m, o5u);
      end
      rxd1  = 1'b1;
      rxd4  = 4'hF;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fall_d3();
      logic [2:0] exp_o;
      exp_o = 3'b011;
      do_reset();
      rxd1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if (o3 !== exp_o[i]) begin
            nerr++; $display("FAIL d3_tick%0d out got %b exp %b", i + 1, o3, exp_o[i]);
         end
      end
      nvec++;
      if (f3 !== 1'b0 || g3 !== 1'b0) begin
         nerr++; $display("FAIL d3_same_cycle got f%b g%b exp 0 0", f3, g3);
      end
      @(posedge clk); #1;
      nvec++;
      if (f3 !== 1'b1) begin
         nerr++; $display("FAIL d3_fall got %b exp 1", f3);
      end
      @(posedge clk); #1;
      nvec++;
      if (f3 !== 1'b0 || g3 !== 1'b0) begin
         nerr++; $display("FAIL d3_fall_end got f%b g%b exp 0 0", f3, g3);
      end
   endtask

   task automatic test_glitch_d5();
      do_reset();
      rxd1 = 1'b0;
      tick();
      rxd1 = 1'b1;
      nvec++;
      if (o5u !== 1'b1 || g5u !== 1'b0) begin
         nerr++; $display("FAIL d5_spike got o%b g%b exp 1 0", o5u, g5u);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         nvec++;
         if (o5u !== 1'b1) begin
            nerr++; $display("FAIL d5_out_t%0d got %b exp 1", k, o5u);
         end
         nvec++;
         if (g5u !== (k == 5)) begin
            nerr++; $display("FAIL d5_glitch_t%0d got %b exp %b", k, g5u, (k == 5));
         end
      end
      @(posedge clk); #1;
      nvec++;
      if (g5u !== 1'b0 || f5u !== 1'b0) begin
         nerr++; $display("FAIL d5_glitch_end got g%b f%b exp 0 0", g5u, f5u);
      end
   endtask

   task automatic test_majority();
      logic [7:0] pat, exp_o, exp_g;
      pat   = 8'b0000_0100;
      exp_o = 8'b0000_0111;
      exp_g = 8'b1000_0000;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         rxd1 = pat[i];
         tick();
         nvec++;
         if (o5m !== exp_o[i]) begin
            nerr++; $display("FAIL maj_out_t%0d got %b exp %b", i + 1, o5m, exp_o[i]);
         end
         nvec++;
         if (g5m !== exp_g[i]) begin
            nerr++; $display("FAIL maj_glitch_t%0d got %b exp %b", i + 1, g5m, exp_g[i]);
         end
         if (i == 3) begin
            @(posedge clk); #1;
            nvec++;
            if (f5m !== 1'b1) begin
               nerr++; $display("FAIL maj_fall got %b exp 1", f5m);
            end
         end
      end
   endtask

   task automatic test_channel();
      logic [3:0] exp_o [3];
      exp_o = '{4'hF, 4'hF, 4'hB};
      do_reset();
      rxd4 = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if (o4 !== exp_o[i] || g4 !== 4'h0) begin
            nerr++; $display("FAIL c4_t%0d got o%h g%h exp o%h g0", i + 1, o4, g4, exp_o[i]);
         end
      end
      @(posedge clk); #1;
      nvec++;
      if (f4 !== 4'b0100) begin
         nerr++; $display("FAIL c4_fall got %b exp 0100", f4);
      end
      @(posedge clk); #1;
      nvec++;
      if (f4 !== 4'h0) begin
         nerr++; $display("FAIL c4_fall_end got %b exp 0000", f4);
      end
   endtask

   task automatic test_rxen_drop();
      logic [2:0] exp_o;
      exp_o = 3'b011;
      do_reset();
      rxd1 = 1'b0;
      repeat (3) tick();
      nvec++;
      if (o3 !== 1'b0) begin
         nerr++; $display("FAIL en_pre got %b exp 0", o3);
      end
      @(posedge clk); #1;
      @(negedge clk);
      rxen = 1'b0;
      rxc  = 1'b1;
      @(posedge clk); #1;
      rxc = 1'b0;
      nvec++;
      if (o3 !== 1'b1 || f3 !== 1'b0 || g3 !== 1'b0) begin
         nerr++; $display("FAIL en_drop got o%b f%b g%b exp 1 0 0", o3, f3, g3);
      end
      @(negedge clk);
      rxen = 1'b1;
      @(posedge clk); #1;
      nvec++;
      if (o3 !== 1'b1 || f3 !== 1'b0 || g3 !== 1'b0) begin
         nerr++; $display("FAIL en_back got o%b f%b g%b exp 1 0 0", o3, f3, g3);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if (o3 !== exp_o[i]) begin
            nerr++; $display("FAIL en_tick%0d got %b exp %b", i + 1, o3, exp_o[i]);
         end
      end
      @(posedge clk); #1;
      nvec++;
      if (f3 !== 1'b1) begin
         nerr++; $display("FAIL en_fall got %b exp 1", f3);
      end
   endtask

   task automatic test_async_reset();
      logic [2:0] exp_o;
      exp_o = 3'b011;
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if (o3 !== 1'b1 || f3 !== 1'b0 || g3 !== 1'b0) begin
         nerr++; $display("FAIL arst got o%b f%b g%b exp 1 0 0", o3, f3, g3);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if (o3 !== exp_o[i]) begin
            nerr++; $display("FAIL arst_tick%0d got %b exp %b", i + 1, o3, exp_o[i]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fall_d3();
      test_glitch_d5();
      test_majority();
      test_channel();
      test_rxen_drop();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
